// File: rtl/soda_pkg.sv
// Shared constants, coin values and acceptor state encodings for the soda coin front end.
package soda_pkg;

    localparam int COIN_VAL_W = 7;

    localparam logic [COIN_VAL_W-1:0] NICKEL_C  = 7'd5;
    localparam logic [COIN_VAL_W-1:0] DIME_C    = 7'd10;
    localparam logic [COIN_VAL_W-1:0] QUARTER_C = 7'd25;
    localparam logic [COIN_VAL_W-1:0] DOLLAR_C  = 7'd100;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        STROBE = 3'b010,
        HOLD   = 3'b100
    } acc_state_t;

    // Bit order of the coin vector: 0 nickel, 1 dime, 2 quarter, 3 dollar.
    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [3:0] rise);
        logic [COIN_VAL_W-1:0] v;
        v = '0;
        if (rise[0])      v = NICKEL_C;
        else if (rise[1]) v = DIME_C;
        else if (rise[2]) v = QUARTER_C;
        else if (rise[3]) v = DOLLAR_C;
        return v;
    endfunction

endpackage

// File: rtl/soda_debounce.sv
// Two-flop synchronizer plus stability counter for one raw coin button.
module soda_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Any sample agreeing with the current level restarts the stability window.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/soda_coin_acceptor.sv
// Coin front end: debounce each button, detect coin edges, strobe accepted coins.
// Define SODA_DOLLAR_EN to add the dollar button and its 100-cent value.
module soda_coin_acceptor
    import soda_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int COUNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_nickel,
    input  logic                  btn_dime,
    input  logic                  btn_quarter,
`ifdef SODA_DOLLAR_EN
    input  logic                  btn_dollar,
`endif
    input  logic                  accept_en,
    input  logic                  tot_clr,
    output logic                  c,
    output logic [COIN_VAL_W-1:0] coin_val,
    output logic                  coin_err,
    output logic                  coin_rej,
    output logic [COUNT_W-1:0]    coin_count
);

    // state  | meaning
    // IDLE   | waiting for a single debounced coin edge
    // STROBE | c high for one cycle, coin_val driven, count bumps at cycle end
    // HOLD   | coin seen; ignore edges until every button is released

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [3:0]            lvl;
    logic [3:0]            prev_q;
    logic [3:0]            rise_q;
    logic                  multi;
    logic                  single;
    acc_state_t            state_q;
    acc_state_t            state_d;
    logic [COIN_VAL_W-1:0] val_q;
    logic [COIN_VAL_W-1:0] val_d;

    soda_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nickel (
        .clk(clk), .rst(rst), .din(btn_nickel), .dout(lvl[0])
    );
    soda_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dime (
        .clk(clk), .rst(rst), .din(btn_dime), .dout(lvl[1])
    );
    soda_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_quarter (
        .clk(clk), .rst(rst), .din(btn_quarter), .dout(lvl[2])
    );
`ifdef SODA_DOLLAR_EN
    soda_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dollar (
        .clk(clk), .rst(rst), .din(btn_dollar), .dout(lvl[3])
    );
`else
    assign lvl[3] = 1'b0;
`endif

    // Edges are registered so the FSM sees a clean one-cycle pulse per coin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
        end
    end

    assign multi  = (rise_q & (rise_q - 4'd1)) != 4'd0;
    assign single = (rise_q != 4'd0) && !multi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        c        = 1'b0;
        coin_err = 1'b0;
        coin_rej = 1'b0;
        case (state_q)
            IDLE: begin
                if (multi) begin
                    coin_err = 1'b1;
                    state_d  = HOLD;
                end else if (single) begin
                    if (accept_en) begin
                        val_d   = coin_value(rise_q);
                        state_d = STROBE;
                    end else begin
                        coin_rej = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            STROBE: begin
                c       = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (lvl == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign coin_val = c ? val_q : '0;

    // Clear wins over a coincident strobe increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin_count <= '0;
        end else if (tot_clr) begin
            coin_count <= '0;
        end else if (state_q == STROBE && coin_count != COUNT_MAX) begin
            coin_count <= coin_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_soda_coin_acceptor.sv
// Scoreboard bench for soda_coin_acceptor with DEBOUNCE_CYCLES = 4 and COUNT_W = 2.
module tb_soda_coin_acceptor;

    localparam int K_C   = 1;
    localparam int K_ERR = 2;
    localparam int K_REJ = 4;

    typedef struct {
        int kind;
        int val;
        int cnt;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       btn_nickel;
    logic       btn_dime;
    logic       btn_quarter;
`ifdef SODA_DOLLAR_EN
    logic       btn_dollar;
`endif
    logic       accept_en;
    logic       tot_clr;
    logic       c;
    logic [6:0] coin_val;
    logic       coin_err;
    logic       coin_rej;
    logic [1:0] coin_count;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   exp_count = 0;

    soda_coin_acceptor #(.DEBOUNCE_CYCLES(4), .COUNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_nickel (btn_nickel),
        .btn_dime   (btn_dime),
        .btn_quarter(btn_quarter),
`ifdef SODA_DOLLAR_EN
        .btn_dollar (btn_dollar),
`endif
        .accept_en  (accept_en),
        .tot_clr    (tot_clr),
        .c          (c),
        .coin_val   (coin_val),
        .coin_err   (coin_err),
        .coin_rej   (coin_rej),
        .coin_count (coin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every c / coin_err / coin_rej presentation pops one expectation.
    logic cnt_pend = 1'b0;
    int   cnt_exp  = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        int   kind;
        if (cnt_pend) begin
            cnt_pend = 1'b0;
            check("count_after_strobe", 32'(coin_count), 32'(cnt_exp));
        end
        if (rst && (c || coin_err || coin_rej)) begin
            kind = (c ? K_C : 0) + (coin_err ? K_ERR : 0) + (coin_rej ? K_REJ : 0);
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(kind), 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", 32'(kind), 32'(e.kind));
                check("event_val", 32'(coin_val), 32'(e.val));
                if (e.cyc >= 0) check("event_cycle", 32'(cyc), 32'(e.cyc));
                if (c) begin
                    cnt_pend = 1'b1;
                    cnt_exp  = e.cnt;
                end else begin
                    check("count_unchanged", 32'(coin_count), 32'(e.cnt));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int kind, input int val, input int cnt, input int at);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cnt  = cnt;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic set_btns(input logic [2:0] m);
        btn_nickel  = m[0];
        btn_dime    = m[1];
        btn_quarter = m[2];
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step(1);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_c"}, 32'(c), 32'd0);
        check({tag, "_coin_val"}, 32'(coin_val), 32'd0);
        check({tag, "_coin_err"}, 32'(coin_err), 32'd0);
        check({tag, "_coin_rej"}, 32'(coin_rej), 32'd0);
        check({tag, "_coin_count"}, 32'(coin_count), 32'd0);
    endtask

    // Press a button set, expect one event dt edges after the press, then release.
    task automatic coin(input logic [2:0] m, input int kind, input int val, input int dt, input string name);
        int p;
        set_btns(m);
        p = cyc;
        if (kind == K_C && exp_count < 3) exp_count++;
        push(kind, val, exp_count, p + dt);
        step(14);
        set_btns(3'b000);
        drain(name);
        step(10);
    endtask

    initial begin
        int p;
        rst       = 1'b0;
        accept_en = 1'b1;
        tot_clr   = 1'b0;
        set_btns(3'b000);
`ifdef SODA_DOLLAR_EN
        btn_dollar = 1'b0;
`endif
        step(2);
        @(negedge clk);
        check_zero("reset");
        step(1);
        rst = 1'b1;
        step(3);

        // Clean quarter: strobe 8 edges after press.
        coin(3'b100, K_C, 25, 8, "drain_quarter");

        // Bouncing dime: the last rise starts the window.
        btn_dime = 1'b1;
        step(1);
        btn_dime = 1'b0;
        step(1);
        btn_dime = 1'b1;
        p = cyc;
        exp_count++;
        push(K_C, 10, exp_count, p + 8);
        step(14);
        btn_dime = 1'b0;
        drain("drain_bounce");
        step(10);

        // Simultaneous nickel+dime, then a lone nickel.
        coin(3'b011, K_ERR, 0, 7, "drain_multi");
        coin(3'b001, K_C, 5, 8, "drain_nickel");

        // Rejected while closed, accepted once reopened; count already saturated at 3.
        accept_en = 1'b0;
        coin(3'b100, K_REJ, 0, 7, "drain_rej");
        accept_en = 1'b1;
        coin(3'b100, K_C, 25, 8, "drain_quarter_sat");

        // tot_clr during STROBE beats the increment.
        btn_nickel = 1'b1;
        p = cyc;
        exp_count = 0;
        push(K_C, 5, 0, p + 8);
        step(8);
        tot_clr = 1'b1;
        step(1);
        tot_clr = 1'b0;
        step(5);
        btn_nickel = 1'b0;
        drain("drain_clr_strobe");
        step(10);

        // Five coins into a 2-bit counter.
        coin(3'b100, K_C, 25, 8, "drain_sat1");
        coin(3'b010, K_C, 10, 8, "drain_sat2");
        coin(3'b001, K_C, 5, 8, "drain_sat3");
        coin(3'b100, K_C, 25, 8, "drain_sat4");
        coin(3'b010, K_C, 10, 8, "drain_sat5");

        // tot_clr while idle.
        tot_clr = 1'b1;
        step(1);
        tot_clr = 1'b0;
        exp_count = 0;
        @(negedge clk);
        check("count_idle_clear", 32'(coin_count), 32'd0);

        // Reset mid-debounce with dime held through release.
        btn_dime = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        step(1);
        rst = 1'b1;
        p = cyc;
        exp_count = 1;
        push(K_C, 10, 1, p + 8);
        step(14);
        btn_dime = 1'b0;
        drain("drain_reset_held");
        step(10);

`ifdef SODA_DOLLAR_EN
        btn_dollar = 1'b1;
        p = cyc;
        exp_count++;
        push(K_C, 100, exp_count, p + 8);
        step(14);
        btn_dollar = 1'b0;
        drain("drain_dollar");
        step(10);
`endif

        step(2);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/soda_coin_acceptor.md
# soda_coin_acceptor

Coin-input front end for the soda machine. It takes raw coin pushbuttons, synchronizes and debounces each one, and produces the single-cycle coin-deposited strobe `c` together with the coin's value in cents. The value is loaded into the total register when the control FSM asserts `tot_ld`. The block sits between the board pushbuttons and the soda control FSM: it generates coin events, and the FSM consumes them. It also honours the FSM's acceptance window and keeps a per-transaction coin count.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable sampled cycles needed before a debounced level changes (minimum 2).
- `COUNT_W`, default 8: width of the accepted-coin counter.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: reset, asynchronous, active-low.
- `btn_nickel` input 1: raw nickel button, asynchronous to `clk`.
- `btn_dime` input 1: raw dime button, asynchronous to `clk`.
- `btn_quarter` input 1: raw quarter button, asynchronous to `clk`.
- `btn_dollar` input 1: raw dollar button. Present only with `SODA_DOLLAR_EN`.
- `accept_en` input 1: high while the control FSM is in its listen/add states. Coins are accepted only while it is high.
- `tot_clr` input 1: clear from the control FSM. Zeroes `coin_count`.
- `c` output 1: coin-deposited strobe, exactly one cycle per accepted coin.
- `coin_val` output 7: coin value in cents. Valid only while `c` = 1, and 0 otherwise.
- `coin_err` output 1: one-cycle pulse when more than one coin is seen at once.
- `coin_rej` output 1: one-cycle pulse when a coin arrives while `accept_en` = 0.
- `coin_count` output `COUNT_W`: number of accepted coins since the last `tot_clr`. Saturates at its maximum value.

## Operation
Debounce path, one instance per button:
- Two-flop synchronizer feeds a stability counter.
- The debounced level changes on the edge at which the synchronized input has differed from the debounced level for `DEBOUNCE_CYCLES` consecutive cycles.
- Any sample that agrees with the debounced level resets the counter to 0.

Edge detection:
- A coin event is a rising edge on any debounced level, computed from the registered previous level.
- Falling edges are ignored.

Acceptor FSM, one-hot, states `IDLE`, `STROBE`, `HOLD`:
- `IDLE`:
  - Exactly one rising edge and `accept_en` = 1: latch the coin value, go to `STROBE`.
  - Exactly one rising edge and `accept_en` = 0: pulse `coin_rej`, go to `HOLD`.
  - Two or more rising edges in the same cycle: pulse `coin_err`, no strobe, go to `HOLD`. This check takes priority over the `accept_en` check.
- `STROBE`: drive `c` = 1 and `coin_val` = the latched value. Increment `coin_count` unless it is saturated. Unconditionally go to `HOLD`.
- `HOLD`: wait until every debounced level is 0, then go to `IDLE`. Rising edges seen in `HOLD` are discarded, with no `coin_err` and no `coin_rej`.

Coin values: nickel 5, dime 10, quarter 25, dollar 100.

`tot_clr`:
- Clears `coin_count` to 0 on the next edge in every state.
- If `tot_clr` and the `STROBE` increment happen in the same cycle, the clear wins: the result is 0.

Reset:
- All outputs go to 0: `c` = 0, `coin_val` = 0, `coin_err` = 0, `coin_rej` = 0, `coin_count` = 0.
- The FSM goes to `IDLE`, synchronizers to 0, debounced levels to 0, stability counters to 0.
- Reset asserted mid-debounce or in `STROBE` aborts the event. No strobe is emitted after reset release until a fresh debounce completes.
- A button already held through reset release debounces to 1 and produces a normal event.

## Timing
- Raw button rise (held stable) to `c` high: 2 synchronizer + `DEBOUNCE_CYCLES` + 2 (edge register, `STROBE`) clock edges.
- `c` is high for exactly one cycle, and `coin_val` is valid in that same cycle.
- `coin_count` updates on the edge that ends `STROBE`.
- Minimum spacing between two `c` pulses: full release, plus `DEBOUNCE_CYCLES` low, plus a new press debounce. Two strobes are never closer than 3 cycles, which leaves the control FSM time for its add→listen turnaround.
- `accept_en` is sampled only in `IDLE`. Deasserting it while in `STROBE` does not cancel the strobe.

## Configuration
- Macro `SODA_DOLLAR_EN`.
- Defined: adds the `btn_dollar` port, a fourth debounce instance, and a coin value of 100. The dollar input takes part in the multiple-coin check.
- Undefined: no dollar port or logic. `coin_val` stays 7 bits wide and never exceeds 25.

## Structure
- `soda_pkg` holds:
  - coin value constants `NICKEL_C`, `DIME_C`, `QUARTER_C`, `DOLLAR_C`;
  - the `COIN_VAL_W` = 7 constant;
  - the acceptor state encodings.
- One sub-module, `soda_debounce`: synchronizer plus stability counter, parameterized by `DEBOUNCE_CYCLES`, with `clk`/`rst` and one in/one out. It is instantiated once per button.

## Test plan
The bench uses `DEBOUNCE_CYCLES` = 4.

1. Quarter pressed for 20 cycles with `accept_en` = 1 → `c` = 1 for one cycle, 8 edges after the press; `coin_val` = 25; `coin_count` 0→1.
2. Dime with bounce (toggling every cycle for 3 cycles, then stable high) → exactly one `c` with `coin_val` = 10.
3. Nickel and dime pressed on the same cycle → `coin_err` pulse, no `c`, `coin_count` unchanged. After both are released, a nickel press gives `c` with `coin_val` = 5.
4. Quarter pressed with `accept_en` = 0 → `coin_rej` pulse, no `c`. Release, set `accept_en` = 1, press again → `c` with `coin_val` = 25.
5. `tot_clr` asserted in the same cycle as `STROBE` → `c` = 1 but `coin_count` = 0. Set `COUNT_W` = 2 and insert 5 coins → `coin_count` saturates at 3.
6. `rst` low for 1 cycle while a debounce is in progress → every output 0. A button held through reset release yields one `c`, 8 edges after release. With `SODA_DOLLAR_EN` defined, a dollar press gives `coin_val` = 100.
